// File: rtl/sym_vn_lut_pipe_if.sv
// sym_vn_lut_pipe_if
//   Bus bundle for the symmetric variable-node LUT pipe: read request/response
//   lanes (per-port packed at [p*QUAN_SIZE +: QUAN_SIZE]) plus the streaming
//   table loader.
//   master : driver of requests and load beats (VNU control / host side)
//   slave  : the LUT pipe itself
interface sym_vn_lut_pipe_if #(
  parameter int QUAN_SIZE = 4,
  parameter int PORT_NUM  = 2
);
  logic                          pipe_en;
  logic [PORT_NUM-1:0]           in_valid;
  logic [PORT_NUM*QUAN_SIZE-1:0] y0_in;
  logic [PORT_NUM*QUAN_SIZE-1:0] y1_in;
  logic                          read_addr_offset;
  logic [PORT_NUM*QUAN_SIZE-1:0] t_c;
  logic [PORT_NUM-1:0]           transpose_en_out;
  logic [PORT_NUM-1:0]           out_valid;
  logic                          read_addr_offset_out;
  logic                          load_start;
  logic                          load_offset;
  logic                          load_valid;
  logic [QUAN_SIZE-1:0]          load_data;
  logic                          load_busy;
  logic                          load_done;

  modport master (
    output pipe_en, in_valid, y0_in, y1_in, read_addr_offset,
           load_start, load_offset, load_valid, load_data,
    input  t_c, transpose_en_out, out_valid, read_addr_offset_out,
           load_busy, load_done
  );

  modport slave (
    input  pipe_en, in_valid, y0_in, y1_in, read_addr_offset,
           load_start, load_offset, load_valid, load_data,
    output t_c, transpose_en_out, out_valid, read_addr_offset_out,
           load_busy, load_done
  );
endinterface

// File: rtl/sym_vn_lut_pipe.sv
// sym_vn_lut_pipe
//   Multi-port symmetric two-input variable-node IB-LUT. Each port folds its
//   (y0, y1) pair around the sign of y0 and reads a shared double-buffered
//   table at {offset, y0f, y1f}. A streaming loader rewrites one table offset
//   while the decoder reads the other.
//
//   Ports:
//     read_clk : clock for read pipeline and loader
//     rstn     : asynchronous active-low reset
//     bus      : sym_vn_lut_pipe_if.slave (requests, results, loader)
//
//   Optional feature macro: SYM_VN_OUT_RESTORE_EN
//     defined   -> extra output stage re-applies the sign (t_c = transpose ? ~word : word),
//                  latency 3
//     undefined -> t_c is the raw table word, latency 2
//
//   Loader FSM:
//     state | meaning
//     IDLE  | waiting for load_start; load_valid ignored
//     LOAD  | writing load_data to {offset, cnt} on each load_valid
module sym_vn_lut_pipe #(
  parameter int QUAN_SIZE = 4,
  parameter int PORT_NUM  = 2,
  parameter int ENTRY_NUM = 2**(2*QUAN_SIZE-1)
) (
  input logic              read_clk,
  input logic              rstn,
  sym_vn_lut_pipe_if.slave bus
);

  localparam int CNT_W = 2*QUAN_SIZE-1;
  localparam int DEPTH = 2*ENTRY_NUM;

  typedef enum logic {IDLE = 1'b0, LOAD = 1'b1} load_state_t;

  logic [QUAN_SIZE-1:0] mem [DEPTH];

  // fold
  logic [QUAN_SIZE-2:0] y0f_c [PORT_NUM];
  logic [QUAN_SIZE-1:0] y1f_c [PORT_NUM];
  logic [PORT_NUM-1:0]  msb_c;

  always_comb begin
    for (int p = 0; p < PORT_NUM; p++) begin
      msb_c[p] = bus.y0_in[p*QUAN_SIZE + QUAN_SIZE-1];
      if (msb_c[p]) begin
        y0f_c[p] = ~bus.y0_in[p*QUAN_SIZE +: QUAN_SIZE-1];
        y1f_c[p] = ~bus.y1_in[p*QUAN_SIZE +: QUAN_SIZE];
      end else begin
        y0f_c[p] = bus.y0_in[p*QUAN_SIZE +: QUAN_SIZE-1];
        y1f_c[p] = bus.y1_in[p*QUAN_SIZE +: QUAN_SIZE];
      end
    end
  end

  // stage 0: folded address pieces
  logic [QUAN_SIZE-2:0] y0f_s0 [PORT_NUM];
  logic [QUAN_SIZE-1:0] y1f_s0 [PORT_NUM];
  logic [PORT_NUM-1:0]  msb_s0;
  logic [PORT_NUM-1:0]  vld_s0;
  logic                 off_s0;

  always_ff @(posedge read_clk or negedge rstn) begin
    if (!rstn) begin
      for (int p = 0; p < PORT_NUM; p++) begin
        y0f_s0[p] <= '0;
        y1f_s0[p] <= '0;
      end
      msb_s0 <= '0;
      vld_s0 <= '0;
      off_s0 <= 1'b0;
    end else if (bus.pipe_en) begin
      for (int p = 0; p < PORT_NUM; p++) begin
        y0f_s0[p] <= y0f_c[p];
        y1f_s0[p] <= y1f_c[p];
      end
      msb_s0 <= msb_c;
      vld_s0 <= bus.in_valid;
      off_s0 <= bus.read_addr_offset;
    end
  end

  // stage 1: table read; a same-cycle write to the same address lands after
  // this sample, so the old word is returned
  logic [QUAN_SIZE-1:0] word_s1 [PORT_NUM];
  logic [PORT_NUM-1:0]  msb_s1;
  logic [PORT_NUM-1:0]  vld_s1;
  logic                 off_s1;

  always_ff @(posedge read_clk or negedge rstn) begin
    if (!rstn) begin
      for (int p = 0; p < PORT_NUM; p++) word_s1[p] <= '0;
      msb_s1 <= '0;
      vld_s1 <= '0;
      off_s1 <= 1'b0;
    end else if (bus.pipe_en) begin
      for (int p = 0; p < PORT_NUM; p++)
        word_s1[p] <= mem[{off_s0, y0f_s0[p], y1f_s0[p]}];
      msb_s1 <= msb_s0;
      vld_s1 <= vld_s0;
      off_s1 <= off_s0;
    end
  end

  logic [QUAN_SIZE-1:0] word_o [PORT_NUM];
  logic [PORT_NUM-1:0]  msb_o;
  logic [PORT_NUM-1:0]  vld_o;
  logic                 off_o;

`ifdef SYM_VN_OUT_RESTORE_EN
  logic [QUAN_SIZE-1:0] word_s2 [PORT_NUM];
  logic [PORT_NUM-1:0]  msb_s2;
  logic [PORT_NUM-1:0]  vld_s2;
  logic                 off_s2;

  always_ff @(posedge read_clk or negedge rstn) begin
    if (!rstn) begin
      for (int p = 0; p < PORT_NUM; p++) word_s2[p] <= '0;
      msb_s2 <= '0;
      vld_s2 <= '0;
      off_s2 <= 1'b0;
    end else if (bus.pipe_en) begin
      for (int p = 0; p < PORT_NUM; p++)
        word_s2[p] <= msb_s1[p] ? ~word_s1[p] : word_s1[p];
      msb_s2 <= msb_s1;
      vld_s2 <= vld_s1;
      off_s2 <= off_s1;
    end
  end

  always_comb begin
    for (int p = 0; p < PORT_NUM; p++) word_o[p] = word_s2[p];
    msb_o = msb_s2;
    vld_o = vld_s2;
    off_o = off_s2;
  end
`else
  always_comb begin
    for (int p = 0; p < PORT_NUM; p++) word_o[p] = word_s1[p];
    msb_o = msb_s1;
    vld_o = vld_s1;
    off_o = off_s1;
  end
`endif

  always_comb begin
    bus.t_c = '0;
    for (int p = 0; p < PORT_NUM; p++)
      bus.t_c[p*QUAN_SIZE +: QUAN_SIZE] = word_o[p];
  end

  assign bus.transpose_en_out     = msb_o;
  assign bus.out_valid            = vld_o;
  assign bus.read_addr_offset_out = off_o;

  // loader
  load_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ld_off_q, ld_off_d;
  logic             done_q, done_d;
  logic             wr_en;

  always_ff @(posedge read_clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      ld_off_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ld_off_q <= ld_off_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ld_off_d = ld_off_q;
    done_d   = 1'b0;
    wr_en    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.load_start) begin
          ld_off_d = bus.load_offset;
          cnt_d    = '0;
          state_d  = LOAD;
        end
      end
      LOAD: begin
        if (bus.load_valid) begin
          wr_en = 1'b1;
          if (cnt_q == CNT_W'(ENTRY_NUM-1)) begin
            cnt_d   = '0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // table contents are deliberately not reset
  always_ff @(posedge read_clk) begin
    if (wr_en) mem[{ld_off_q, cnt_q}] <= bus.load_data;
  end

  assign bus.load_busy = (state_q == LOAD);
  assign bus.load_done = done_q;

endmodule

// File: doc/sym_vn_lut_pipe.md
# sym_vn_lut_pipe

Parametrised, multi-port, symmetric two-input variable-node IB-LUT with a built-in streaming LUT loader. It folds each input pair around the sign bit of y0 and looks up the folded pair in a double-buffered (two-offset) table. It returns the folded result plus a transpose flag per port, with valid tracking and a global stall. It sits in the partial VNU between the channel/message buffers and the transpose/accumulate stage. The host reloads one table offset while the decoder reads the other.

## Interface
Parameters:
- QUAN_SIZE, 4, message width in bits; folded y0 uses QUAN_SIZE-1 bits, y1 uses QUAN_SIZE bits.
- PORT_NUM, 2, number of independent read ports sharing one table.
- ENTRY_NUM, 2**(2*QUAN_SIZE-1), entries per offset (derived; do not override).

Ports:
- read_clk  in  1  single clock for read pipeline and loader.
- rstn  in  1  asynchronous, active-low reset.
- pipe_en  in  1  global pipeline advance; low holds every read stage.
- in_valid  in  PORT_NUM  per-port request valid.
- y0_in  in  PORT_NUM*QUAN_SIZE  first message per port, port p at [p*QUAN_SIZE +: QUAN_SIZE].
- y1_in  in  PORT_NUM*QUAN_SIZE  second message per port, same packing.
- read_addr_offset  in  1  table offset used by all ports for this request.
- t_c  out  PORT_NUM*QUAN_SIZE  folded LUT output per port.
- transpose_en_out  out  PORT_NUM  y0 sign bit, delayed to align with t_c.
- out_valid  out  PORT_NUM  per-port result valid.
- read_addr_offset_out  out  1  offset, delayed to align with t_c.
- load_start  in  1  one-cycle request to begin reloading an offset.
- load_offset  in  1  offset to reload; sampled with load_start.
- load_valid  in  1  load_data is presented this cycle.
- load_data  in  QUAN_SIZE  table entry, written in ascending address order.
- load_busy  out  1  loader is in LOAD.
- load_done  out  1  one-cycle pulse when the last entry is written.

## Operation
- Fold per port:
  - If y0[MSB]=1: y0f = ~y0[QUAN_SIZE-2:0] and y1f = ~y1.
  - Otherwise: y0f = y0[QUAN_SIZE-2:0] and y1f = y1.
  - Table address = {offset, y0f, y1f}, 2*ENTRY_NUM words of QUAN_SIZE bits.
- t_c is the raw table word. No sign restoration is applied unless the macro below is defined.
- Loader FSM, states IDLE, LOAD:
  - In IDLE, load_start=1 latches load_offset, clears the entry counter to 0 and moves to LOAD.
  - In LOAD, each load_valid=1 writes load_data to {offset, cnt}, then cnt increments.
  - The write with cnt=ENTRY_NUM-1 pulses load_done in the next cycle, and the FSM returns to IDLE with cnt wrapped to 0.
  - load_start is ignored in LOAD.
  - load_valid is ignored in IDLE.
- Writes do not depend on pipe_en.
- Read/write collision on the same address in the same cycle: the read returns the old word (read-before-write).
- Reads of the offset being loaded return unspecified data; reads of the other offset are unaffected.
- Reset mid-load: the FSM goes to IDLE and cnt to 0. Table contents are not reset and are undefined until loaded.

## Timing
- Stage 0 registers fold results, the msb, in_valid and the offset. Stage 1 registers the table read.
- Latency is 2 cycles from in_valid to out_valid while pipe_en=1, with full throughput of 1 request per port per cycle.
- pipe_en=0 freezes both stages and all outputs. Inputs presented during the stall are dropped.
- Bubbles: in_valid=0 propagates as out_valid=0. t_c is don't-care when out_valid=0.
- Reset values:
  - t_c=0, transpose_en_out=0, out_valid=0, read_addr_offset_out=0.
  - load_busy=0, load_done=0, all pipeline registers 0.
- load_busy rises the cycle after load_start and falls in the same cycle load_done pulses.

## Configuration
- SYM_VN_OUT_RESTORE_EN:
  - Defined: an extra output stage applies t_c = transpose ? ~word : word, and transpose_en_out is still driven. Latency becomes 3 cycles and pipe_en stalls the extra stage too.
  - Undefined: t_c is the raw word and latency is 2.

## Test plan
- Reset with random inputs: all outputs 0 and load_busy=0 until rstn rises; no out_valid for 2 cycles after.
- Load offset 0 with entry k = k[3:0] (128 beats, gaps inserted in load_valid): load_done pulses exactly once after beat 127, and load_busy spans the load.
- Port 0 y0=4'b0010, y1=4'b0110 on offset 0 -> after 2 cycles t_c[3:0]=6, transpose_en_out[0]=0, out_valid[0]=1. Same cycle, port 1 y0=4'b1101, y1=4'b1001 -> t_c[7:4]=6, transpose_en_out[1]=1.
- Back-to-back requests with pipe_en low for 3 cycles mid-stream: outputs hold, order is preserved and no result is lost or duplicated.
- Load offset 1 (entry k = ~k[3:0]) while streaming reads on offset 0: offset-0 results are unchanged; after load_done, the same inputs on offset 1 give 9. load_start during LOAD is ignored.
- With SYM_VN_OUT_RESTORE_EN defined: port 1 case above gives t_c=4'b1001 after 3 cycles.
